// File: rtl/cmd_rx_capture.sv
// GMII receive capture for command frames: strips preamble/SFD, filters on EtherType,
// checks FCS and writes frames into a two-bank RX memory published via valid/ack.
module cmd_rx_capture #(
  parameter logic [15:0] ETHERTYPE  = 16'h88B5,
  parameter int unsigned MIN_LEN    = 64,
  parameter int unsigned BANK_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  output logic        mem_we,
  output logic [10:0] mem_ad,
  output logic [8:0]  mem_din,
  output logic        frm_valid,
  output logic        frm_bank,
  output logic [10:0] frm_len,
  input  logic        frm_ack,
  output logic [15:0] crc_err_cnt,
  output logic [15:0] busy_drop_cnt
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  state_t      state, state_n;
  logic [10:0] idx, idx_n;
  logic [31:0] crc, crc_n;
  logic        et_hi_ok, et_hi_ok_n;
  logic        wr, publish, crc_inc, busy_inc;
  logic        wr_bank, rd_bank;
  logic [1:0]  full;
  logic [10:0] len [2];

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++)
      r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? 32'hEDB88320 : '0);
    return r;
  endfunction

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    crc_n      = crc;
    et_hi_ok_n = et_hi_ok;
    wr         = 1'b0;
    publish    = 1'b0;
    crc_inc    = 1'b0;
    busy_inc   = 1'b0;
    case (state)
      IDLE: if (rx_dv) state_n = (rxd == 8'h55) ? PREAMBLE : DROP;
      PREAMBLE: begin
        if (!rx_dv) state_n = IDLE;
        else if (rxd == 8'hD5) begin
          if (full[wr_bank]) begin
            state_n  = DROP;
            busy_inc = 1'b1;
          end else begin
            state_n = DATA;
            idx_n   = '0;
            crc_n   = '1;
          end
        end else if (rxd != 8'h55) state_n = IDLE;
      end
      DATA: begin
        if (!rx_dv) begin
          state_n = IDLE;
          if (idx >= 11'(MIN_LEN) && crc == CRC_RESIDUE) publish = 1'b1;
          else crc_inc = 1'b1;
        end else if (rx_er || idx == 11'(BANK_WORDS)) begin
          state_n = DROP;
          crc_inc = 1'b1;
        end else begin
          wr    = 1'b1;
          idx_n = idx + 11'd1;
          crc_n = crc_byte(crc, rxd);
          if (idx == 11'd12) et_hi_ok_n = (rxd == ETHERTYPE[15:8]);
          // Both EtherType bytes are written; the frame is abandoned only after byte 13.
          if (idx == 11'd13 && !(et_hi_ok && rxd == ETHERTYPE[7:0])) state_n = DROP;
        end
      end
      DROP: if (!rx_dv) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      crc           <= '1;
      et_hi_ok      <= 1'b0;
      mem_we        <= 1'b0;
      mem_ad        <= '0;
      mem_din       <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      full          <= '0;
      len[0]        <= '0;
      len[1]        <= '0;
      crc_err_cnt   <= '0;
      busy_drop_cnt <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      crc      <= crc_n;
      et_hi_ok <= et_hi_ok_n;
      mem_we   <= wr;
      if (wr) begin
        mem_ad  <= {wr_bank, idx[9:0]};
        mem_din <= {idx == 11'd0, rxd};
      end
      // Publish and release always target different banks, so both may apply together.
      if (publish) begin
        full[wr_bank] <= 1'b1;
        len[wr_bank]  <= idx - 11'd4;
        wr_bank       <= ~wr_bank;
      end
      if (frm_ack && full[rd_bank]) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      if (crc_inc && crc_err_cnt != '1) crc_err_cnt <= crc_err_cnt + 16'd1;
      if (busy_inc && busy_drop_cnt != '1) busy_drop_cnt <= busy_drop_cnt + 16'd1;
    end
  end

  assign frm_valid = full[rd_bank];
  assign frm_bank  = rd_bank;
  assign frm_len   = len[rd_bank];

endmodule

// File: doc/cmd_rx_capture.md
Name: cmd_rx_capture

Overview:
- Receive-side counterpart of the command TX packet memory.
- Takes GMII receive bytes and strips preamble/SFD.
- Filters command frames by EtherType, checks FCS, and writes accepted frames into a 2048x9 simple dual-port RX command memory (write port driven here), organised as two 1024-word banks.
- Publishes completed good frames to the command parser through a valid/ack handshake. Bad frames are discarded and counted.

Parameters:
- ETHERTYPE, 16'h88B5, EtherType accepted as a command frame (bytes 12-13, big-endian).
- MIN_LEN, 64, minimum frame length in bytes incl. FCS; shorter frames are runts.
- BANK_WORDS, 1024, words per bank; frames longer than this are overflows.

Ports:
- clk  in  1  GMII RX clock (125 MHz); sole clock.
- reset  in  1  synchronous, active-high reset.
- rx_dv  in  1  GMII receive data valid.
- rx_er  in  1  GMII receive error.
- rxd  in  8  GMII receive data.
- mem_we  out  1  RX memory write enable.
- mem_ad  out  11  RX memory write address; [10]=bank, [9:0]=offset.
- mem_din  out  9  [8]=start-of-frame flag (1 on byte 0 only), [7:0]=byte.
- frm_valid  out  1  a completed good frame is available.
- frm_bank  out  1  bank holding the oldest available frame.
- frm_len  out  11  byte count of that frame, FCS excluded.
- frm_ack  in  1  consumer releases the bank indicated by frm_bank.
- crc_err_cnt  out  16  saturating count of FCS/rx_er/runt/overflow drops.
- busy_drop_cnt  out  16  saturating count of frames dropped because both banks were full.

Behaviour:
- Reset values: all outputs 0; both banks empty; wr_bank=0; rd_bank=0; FSM in IDLE.
- FSM states:
  - IDLE: on rx_dv=1 with rxd=8'h55 -> PREAMBLE. On rx_dv=1 otherwise -> DROP (no count).
  - PREAMBLE: rxd=8'h55 stays. rxd=8'hD5 -> DATA if the target bank wr_bank is empty, else DROP and busy_drop_cnt++. Any other byte, or rx_dv=0 -> IDLE.
  - DATA: every byte with rx_dv=1 is written and the byte index increments. Byte 12/13 mismatch with ETHERTYPE -> DROP (no count). Index reaching BANK_WORDS with rx_dv still 1 -> DROP, crc_err_cnt++. rx_er=1 -> DROP, crc_err_cnt++. rx_dv=0 -> END check.
  - END check (same cycle rx_dv=0 is first seen in DATA):
    - Good frame = length>=MIN_LEN and CRC register == 32'hDEBB20E3 (reflected CRC-32, poly 0xEDB88320, init 32'hFFFFFFFF, run over all DATA bytes incl. FCS).
    - Good: next cycle the bank is marked full, length-4 is stored as its frame length, and wr_bank toggles.
    - Bad: crc_err_cnt++, bank left empty. Either way -> IDLE.
  - DROP: wait for rx_dv=0 -> IDLE. Bytes already written to the bank are abandoned; no clean-up writes.
- Write timing:
  - mem_we/mem_ad/mem_din registered, one cycle after the byte is sampled.
  - mem_ad = {wr_bank, index}. mem_din[8]=1 only for index 0.
  - No write occurs in DROP, PREAMBLE, or IDLE.
- Handshake:
  - frm_valid = bank rd_bank full. frm_bank = rd_bank. frm_len = that bank's stored length.
  - frm_ack with frm_valid=1 clears the bank and toggles rd_bank; the next frame, if present, appears the following cycle.
  - frm_ack with frm_valid=0 is ignored.
  - Ack and publish in the same cycle are both applied: a publish into the bank being released is impossible because that bank was full at SFD time.
- Ordering: frames are delivered in arrival order (strict ping-pong).
- Counters: 16-bit, saturate at 16'hFFFF, cleared only by reset.
- Reset mid-frame: the frame is lost, banks are emptied, and the FSM waits in IDLE/DROP until rx_dv=0 before accepting a new preamble.

Test Plan:
- 7x55+D5, 64-byte frame with ETHERTYPE 88B5 and correct FCS -> 64 writes at addr 0..63, din[8]=1 only at addr 0; frm_valid=1 one cycle after end, frm_bank=0, frm_len=60.
- Same frame with 1 FCS bit flipped -> no frm_valid, crc_err_cnt=1, wr_bank stays 0.
- Three good frames, no ack -> frames 1/2 in banks 0/1, third gives busy_drop_cnt=1. Ack -> frm_bank=1 next cycle; second ack -> frm_valid=0.
- Frame with EtherType 0800 -> writes stop after byte 13, no valid, both counters unchanged.
- 1030-byte frame -> crc_err_cnt=1, no valid. A 40-byte good-CRC runt -> crc_err_cnt=2.
- rx_er pulse mid-frame, and a separate reset pulse mid-frame -> frame discarded, no valid. The next clean frame is received correctly into bank 0.
